// File: rtl/countdown_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit limit
// and the per-digit clamp applied to load values.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_MAX        = 9;
  localparam int DIGITS_DEFAULT = 2;

  // Non-decimal nibbles are forced to the largest BCD digit.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'(BCD_MAX)) ? 4'(BCD_MAX) : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; decrements when enabled and borrowed into,
// wrapping 0 -> 9 and passing the borrow on combinationally.
module bcd_down_digit
  import countdown_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       enable,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (enable && borrow_in) begin
      r_q <= (r_q == 4'd0) ? 4'(BCD_MAX) : r_q - 4'd1;
    end
  end

  assign q          = r_q;
  assign borrow_out = borrow_in && (r_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// Cascaded BCD countdown timer with IDLE/RUN/DONE control and a one-cycle
// expired pulse. Define COUNTDOWN_AUTORELOAD_EN to restart from the last load value.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                tick,
  input  logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                expired
);

  localparam logic [4*DIGITS-1:0] BCD_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_next;
  logic                r_running;
  logic                r_expired;
  logic                w_expire_next;
  logic                w_load;
  logic                w_dec;
  logic [4*DIGITS-1:0] w_load_data;
  logic [4*DIGITS-1:0] w_value_clamped;
  logic [4*DIGITS-1:0] w_q;
  logic [DIGITS:0]     w_borrow;
  logic                w_all_zero;
  logic                w_value_zero;
  logic                w_is_one;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [4*DIGITS-1:0] r_reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reload <= '0;
    end else if (start) begin
      r_reload <= w_value_clamped;
    end
  end
`endif

  // Digit 0 always sees a borrow request; the final borrow_out means all digits are zero.
  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_value_clamped[4*gi +: 4] = clamp_bcd(value[4*gi +: 4]);

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .d          (w_load_data[4*gi +: 4]),
        .enable     (w_dec),
        .borrow_in  (w_borrow[gi]),
        .q          (w_q[4*gi +: 4]),
        .borrow_out (w_borrow[gi+1])
      );
    end
  endgenerate

  assign w_all_zero   = w_borrow[DIGITS];
  assign w_value_zero = (value == '0);
  assign w_is_one     = (w_q == BCD_ONE);

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_load_data   = w_value_clamped;
    w_dec         = 1'b0;
    w_expire_next = 1'b0;
    if (start) begin
      w_load = 1'b1;
      if (w_value_zero) begin
        w_state_next  = DONE;
        w_expire_next = 1'b1;
      end else begin
        w_state_next = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (stop) begin
            w_state_next = IDLE;
          end else if (tick && !w_all_zero) begin
            w_dec = 1'b1;
            if (w_is_one) begin
              w_state_next  = DONE;
              w_expire_next = 1'b1;
            end
          end
        end
        DONE: begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (r_reload != '0) begin
            w_load       = 1'b1;
            w_load_data  = r_reload;
            w_state_next = RUN;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == RUN);
      r_expired <= w_expire_next;
    end
  end

  assign count   = w_q;
  assign running = r_running;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (DIGITS=2); expectations
// follow COUNTDOWN_AUTORELOAD_EN when it is defined for the build.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       tick;
  logic [7:0] value;
  logic [7:0] count;
  logic       running;
  logic       expired;

  int total_cnt;
  int bad_cnt;

  countdown_timer #(.DIGITS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .tick    (tick),
    .value   (value),
    .count   (count),
    .running (running),
    .expired (expired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
    value = 8'h00;
    #1;
    check_val("rst_count", count, 8'h00);
    check_val("rst_running", running, 1'b0);
    check_val("rst_expired", expired, 1'b0);
    step();
    step();
    reset = 1'b0;

    // Asynchronous reset mid-countdown
    start = 1'b1; value = 8'h42;
    step();
    start = 1'b0;
    check_val("load42_count", count, 8'h42);
    check_val("load42_running", running, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_rst_count", count, 8'h00);
    check_val("async_rst_running", running, 1'b0);
    check_val("async_rst_expired", expired, 1'b0);
    step();
    reset = 1'b0;
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    check_val("post_rst_idle_count", count, 8'h00);
    check_val("post_rst_idle_running", running, 1'b0);

    // Load 12 and count down through the 10 -> 09 borrow to zero
    start = 1'b1; value = 8'h12;
    step();
    start = 1'b0;
    check_val("load12_count", count, 8'h12);
    check_val("load12_running", running, 1'b1);
    tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val($sformatf("cd12_count_%0d", k), count, to_bcd(12 - k));
      check_val($sformatf("cd12_expired_%0d", k), expired, (k == 12) ? 1'b1 : 1'b0);
    end
    check_val("cd12_done_running", running, 1'b0);
    tick = 1'b0;
    step();
    check_val("cd12_expired_low", expired, 1'b0);
`ifdef COUNTDOWN_AUTORELOAD_EN
    check_val("cd12_reload_count", count, 8'h12);
    check_val("cd12_reload_running", running, 1'b1);
`else
    check_val("cd12_hold_count", count, 8'h00);
    check_val("cd12_hold_running", running, 1'b0);
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    check_val("cd12_done_tick_count", count, 8'h00);
    check_val("cd12_done_tick_expired", expired, 1'b0);
`endif

    // Clamp and borrow
    start = 1'b1; value = 8'h1F;
    step();
    start = 1'b0;
    check_val("clamp_count", count, 8'h19);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_val("clamp_tick_count", count, 8'h18);
    start = 1'b1; value = 8'h10;
    step();
    start = 1'b0;
    check_val("load10_count", count, 8'h10);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_val("borrow_count", count, 8'h09);

    // Priority: start beats stop and tick; stop freezes the count
    start = 1'b1; stop = 1'b1; tick = 1'b1; value = 8'h05;
    step();
    start = 1'b0; tick = 1'b0;
    check_val("prio_count", count, 8'h05);
    check_val("prio_running", running, 1'b1);
    step();
    stop = 1'b0;
    check_val("stop_running", running, 1'b0);
    check_val("stop_count", count, 8'h05);
    tick = 1'b1;
    for (int k = 0; k < 3; k++) step();
    tick = 1'b0;
    check_val("stop_frozen_count", count, 8'h05);
    check_val("stop_frozen_running", running, 1'b0);

    // Zero load goes straight to DONE
    start = 1'b1; value = 8'h00;
    step();
    start = 1'b0;
    check_val("zero_expired", expired, 1'b1);
    check_val("zero_running", running, 1'b0);
    check_val("zero_count", count, 8'h00);
    tick = 1'b1;
    step();
    check_val("zero_expired_low", expired, 1'b0);
    check_val("zero_tick_count", count, 8'h00);
    step();
    tick = 1'b0;
    check_val("zero_tick2_count", count, 8'h00);
    check_val("zero_tick2_running", running, 1'b0);

    // Autoreload behaviour from value 02
    start = 1'b1; value = 8'h02;
    step();
    start = 1'b0;
    tick = 1'b1;
    step();
    check_val("ar_count1", count, 8'h01);
    step();
    tick = 1'b0;
    check_val("ar_count0", count, 8'h00);
    check_val("ar_expired", expired, 1'b1);
    step();
    check_val("ar_expired_low", expired, 1'b0);
`ifdef COUNTDOWN_AUTORELOAD_EN
    check_val("ar_reload_count", count, 8'h02);
    check_val("ar_reload_running", running, 1'b1);
`else
    check_val("ar_hold_count", count, 8'h00);
    check_val("ar_hold_running", running, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: DIGITS, default 2, number of cascaded BCD digits; count width is 4*DIGITS.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  load value and begin counting down.
REQ-005 Port: stop  input  1  abort the countdown and hold the count.
REQ-006 Port: tick  input  1  one-cycle count-enable strobe, e.g. from a 1 Hz divider.
REQ-007 Port: value  input  4*DIGITS  BCD load value, least significant digit at [3:0].
REQ-008 Port: count  output  4*DIGITS  current BCD count.
REQ-009 Port: running  output  1  high while in state RUN.
REQ-010 Port: expired  output  1  one-cycle pulse when the countdown reaches zero.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; running SHALL equal (state==RUN), registered.
REQ-012 start in any state SHALL load count<=value and set state<=RUN on the same edge; value is also captured in reload register.
REQ-013 Any value digit >9 SHALL be clamped to 9 on load.
REQ-014 start with value==0 SHALL go directly to DONE and pulse expired on the next edge.
REQ-015 In RUN with tick=1 the count SHALL decrement by 1 in BCD; a digit at 0 SHALL wrap to 9 and borrow from the next digit.
REQ-016 A decrement from 1 to 0 SHALL set state<=DONE and expired<=1 on the same edge; expired SHALL be low the following cycle.
REQ-017 tick SHALL be ignored in IDLE and DONE; count SHALL hold.
REQ-018 stop in RUN SHALL set state<=IDLE with count held; stop in IDLE/DONE SHALL have no effect.
REQ-019 When start and stop are both high, start SHALL win.
REQ-020 When start and tick are both high, the load SHALL win and no decrement SHALL occur that edge.
REQ-021 DONE SHALL hold count==0 until start or reset.
REQ-022 Count SHALL never underflow below all-zeros.

Reset
REQ-023 reset SHALL immediately force state=IDLE, count=0, running=0, expired=0 and reload register=0, independent of clk.
REQ-024 reset asserted mid-countdown SHALL abandon the countdown; after release the block SHALL remain in IDLE until start.

Configuration
REQ-025 With COUNTDOWN_AUTORELOAD_EN defined, DONE SHALL reload count from the reload register and return to RUN on the edge after expired.
REQ-026 If the reload register is 0 under COUNTDOWN_AUTORELOAD_EN, the block SHALL stay in DONE.
REQ-027 Without COUNTDOWN_AUTORELOAD_EN, the reload register and auto-restart logic SHALL be absent and DONE SHALL behave per REQ-021.

Structure
REQ-028 Package countdown_pkg SHALL hold the state encoding (IDLE, RUN, DONE), BCD_MAX=9 and the default DIGITS.
REQ-029 Sub-module bcd_down_digit SHALL implement one 4-bit synchronous down digit with load, enable, borrow_in, q and combinational borrow_out=(borrow_in && q==0); countdown_timer SHALL instantiate DIGITS of them cascaded by borrow.

Verification
REQ-030 Reset: assert reset mid-cycle with count=42 -> count=00, running=0 and expired=0 before the next clk edge.
REQ-031 Load and count: start with value=8'h12, then 12 ticks -> count 12,11,10,09...01,00; expired high for exactly one cycle on reaching 00; state DONE.
REQ-032 Borrow and clamp: start with value=8'h1F -> count=19; one tick -> 18; value=8'h10, one tick -> 09.
REQ-033 Priority: start+stop+tick on the same edge with value=8'h05 -> count=05, running=1; stop alone then ticks -> count frozen, running=0.
REQ-034 Zero load: start with value=8'h00 -> DONE next edge, expired pulses once, count stays 00 under further ticks.
REQ-035 Autoreload (macro defined): value=8'h02, 2 ticks -> expired pulse, then count=02 and running=1 on the next edge; macro undefined -> count stays 00.
